// File: rtl/resp_cmp_pkg.sv
// Shared types for the response comparator: FSM state, mismatch record and
// the default compare/index widths.
package resp_cmp_pkg;

  localparam int CMP_WIDTH = 2;
  localparam int CMP_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMP_IDX_W-1:0] idx;
    logic [CMP_WIDTH-1:0] got;
    logic [CMP_WIDTH-1:0] exp;
  } mm_rec_t;

endpackage

// File: rtl/resp_compare_if.sv
// Vector handshake and mismatch-log read bus of resp_compare.
interface resp_compare_if
  import resp_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int IDX_W = CMP_IDX_W
);

  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] got;
  logic [WIDTH-1:0] exp;
  logic             log_rd;
  logic             log_empty;
  logic [IDX_W-1:0] log_idx;
  logic [WIDTH-1:0] log_got;
  logic [WIDTH-1:0] log_exp;

  modport master (
    output vec_valid, got, exp, log_rd,
    input  vec_ready, log_empty, log_idx, log_got, log_exp
  );

  modport slave (
    input  vec_valid, got, exp, log_rd,
    output vec_ready, log_empty, log_idx, log_got, log_exp
  );

endinterface

// File: rtl/resp_compare_mm_log_fifo.sv
// First-word-fall-through FIFO of mismatch records with a sticky overflow flag.
module mm_log_fifo
  import resp_cmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_clr,
  input  logic    i_push,
  input  logic    i_pop,
  input  mm_rec_t i_din,
  output mm_rec_t o_dout,
  output logic    o_full,
  output logic    o_empty,
  output logic    o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_ovf;
  mm_rec_t       r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop frees the head slot on the same edge, so a full log still accepts a push.
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/resp_compare.sv
// Compares reduced-model output against original-model output per vector,
// counts and logs mismatches, and reports pass/fail after NUM_VEC vectors.
module resp_compare
  import resp_cmp_pkg::*;
#(
  parameter int WIDTH     = CMP_WIDTH,
  parameter int NUM_VEC   = 16,
  parameter int IDX_W     = CMP_IDX_W,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  resp_compare_if.slave    bus,
  output logic             o_log_ovf,
  output logic [IDX_W-1:0] o_mm_count,
  output logic             o_done,
  output logic             o_pass
);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_mm_count;

  logic    w_run;
  logic    w_accept;
  logic    w_mismatch;
  logic    w_clr;
  logic    w_last;
  logic    w_full;
  mm_rec_t w_rec;
  mm_rec_t w_head;

  assign w_run      = (r_state == RUN);
  assign w_accept   = bus.vec_valid & w_run;
  assign w_mismatch = w_accept & (bus.got != bus.exp);
  assign w_clr      = i_start & ~w_run;
  assign w_last     = (r_idx == IDX_W'(NUM_VEC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_mm_count <= '0;
    end else if (w_clr) begin
      r_state    <= RUN;
      r_idx      <= '0;
      r_mm_count <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + 1'b1;
      if (w_mismatch && (r_mm_count != '1)) r_mm_count <= r_mm_count + 1'b1;
      if (w_last) r_state <= DONE;
    end
  end

  assign w_rec = '{idx: r_idx, got: bus.got, exp: bus.exp};

  mm_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_mismatch),
    .i_pop   (bus.log_rd),
    .i_din   (w_rec),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (bus.log_empty),
    .o_ovf   (o_log_ovf)
  );

  assign bus.vec_ready = w_run;
  assign bus.log_idx   = w_head.idx;
  assign bus.log_got   = w_head.got;
  assign bus.log_exp   = w_head.exp;

  assign o_mm_count = r_mm_count;
  assign o_done     = (r_state == DONE);
  assign o_pass     = o_done & (r_mm_count == '0);

endmodule

// File: tb/tb_resp_compare.sv
// Scoreboard bench for resp_compare: a queue-based reference model predicts
// per-cycle status and log head; a monitor pops and compares each cycle.
module tb_resp_compare;

  localparam int WIDTH     = 2;
  localparam int NUM_VEC   = 16;
  localparam int IDX_W     = 8;
  localparam int LOG_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             log_ovf;
  logic [IDX_W-1:0] mm_count;
  logic             done;
  logic             pass;

  resp_compare_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  resp_compare #(
    .WIDTH     (WIDTH),
    .NUM_VEC   (NUM_VEC),
    .IDX_W     (IDX_W),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .bus        (bus),
    .o_log_ovf  (log_ovf),
    .o_mm_count (mm_count),
    .o_done     (done),
    .o_pass     (pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: run flag, vector count, mismatch count and log as a queue.
  typedef struct { int idx; int got; int exp; } lrec_t;
  typedef struct {
    bit ready; bit done; bit pass; bit empty; bit ovf;
    int cnt; int hidx; int hgot; int hexp;
  } st_t;

  bit    m_run, m_fin, m_ovf;
  int    m_idx, m_cnt;
  lrec_t m_log[$];
  st_t   sq[$];

  task automatic model_edge(bit s, bit v, int g, int e, bit r);
    bit    popped;
    int    sz;
    lrec_t rec;
    if (rst) begin
      m_run = 0; m_fin = 0; m_ovf = 0; m_idx = 0; m_cnt = 0;
      m_log.delete();
    end else if (!m_run && s) begin
      m_run = 1; m_fin = 0; m_ovf = 0; m_idx = 0; m_cnt = 0;
      m_log.delete();
    end else begin
      sz = m_log.size();
      popped = r && (sz > 0);
      if (popped) void'(m_log.pop_front());
      if (m_run && v) begin
        if (g != e) begin
          if (m_cnt < (1 << IDX_W) - 1) m_cnt++;
          if (sz < LOG_DEPTH || popped) begin
            rec.idx = m_idx; rec.got = g; rec.exp = e;
            m_log.push_back(rec);
          end else begin
            m_ovf = 1;
          end
        end
        m_idx++;
        if (m_idx == NUM_VEC) begin
          m_run = 0; m_fin = 1;
        end
      end
    end
  endtask

  task automatic push_status();
    st_t s;
    s.ready = m_run;
    s.done  = m_fin;
    s.pass  = m_fin && (m_cnt == 0);
    s.empty = (m_log.size() == 0);
    s.ovf   = m_ovf;
    s.cnt   = m_cnt;
    s.hidx  = s.empty ? 0 : m_log[0].idx;
    s.hgot  = s.empty ? 0 : m_log[0].got;
    s.hexp  = s.empty ? 0 : m_log[0].exp;
    sq.push_back(s);
  endtask

  // Called at posedge+1: drive inputs for the next edge, then model that edge.
  task automatic step(bit s, bit v, logic [1:0] g, logic [1:0] e, bit r);
    start = s; bus.vec_valid = v; bus.got = g; bus.exp = e; bus.log_rd = r;
    @(posedge clk);
    #1;
    model_edge(s, v, int'(g), int'(e), r);
    push_status();
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 2'b00, r);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_vec_ready"}, bus.vec_ready, 0);
    check({tag, "_mm_count"}, mm_count, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_log_ovf"}, log_ovf, 0);
    check({tag, "_log_empty"}, bus.log_empty, 1);
    check({tag, "_log_idx"}, bus.log_idx, 0);
    check({tag, "_log_got"}, bus.log_got, 0);
    check({tag, "_log_exp"}, bus.log_exp, 0);
  endtask

  // Monitor: compare DUT outputs against each predicted cycle status.
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("vec_ready", bus.vec_ready, s.ready);
        check("done", done, s.done);
        check("pass", pass, s.pass);
        check("mm_count", mm_count, s.cnt);
        check("log_empty", bus.log_empty, s.empty);
        check("log_ovf", log_ovf, s.ovf);
        check("log_idx", bus.log_idx, s.hidx);
        check("log_got", bus.log_got, s.hgot);
        check("log_exp", bus.log_exp, s.hexp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g, e;
    bit v, s, r;
    int budget;

    bus.vec_valid = 0; bus.got = '0; bus.exp = '0; bus.log_rd = 0;
    #2 rst = 1;
    #1 check_reset_outputs("por");
    @(posedge clk); #1;
    idle(2, 0);
    rst = 0;
    idle(1, 0);

    // All vectors match
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < NUM_VEC; i++) step(0, 1, 2'b10, 2'b10, 0);
    idle(2, 0);

    // Single mismatch on vector 5, then drain it
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < NUM_VEC; i++)
      step(0, 1, (i == 5) ? 2'b01 : 2'b10, (i == 5) ? 2'b11 : 2'b10, 0);
    idle(2, 0);
    idle(1, 1);
    idle(1, 1);

    // Overflow: mismatches on 0..5 with no pops, then drain in order
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < NUM_VEC; i++) begin
      g = 2'(i);
      step(0, 1, g, (i < 6) ? ~g : g, 0);
    end
    idle(1, 0);
    idle(5, 1);

    // Full log with a pop on the same cycle as the mismatch on vector 4
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < NUM_VEC; i++) begin
      g = 2'(i + 1);
      step(0, 1, g, (i < 5) ? ~g : g, i == 4);
    end
    idle(1, 0);
    idle(5, 1);

    // Backpressure with start pulses mid-run (on idle and accept cycles)
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 2 * NUM_VEC + 2; i++) begin
      g = 2'(i);
      step(i == 5 || i == 8, (i % 2) == 0, g, (i % 6 == 0) ? ~g : g, 0);
    end
    idle(2, 0);

    // Reset mid-run after 7 accepts with 2 mismatches
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 7; i++)
      step(0, 1, 2'b01, (i == 2 || i == 4) ? 2'b10 : 2'b01, 0);
    @(negedge clk);
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    idle(2, 0);
    rst = 0;
    step(1, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < NUM_VEC; i++) step(0, 1, 2'b11, 2'b11, 0);
    idle(2, 0);

    // Randomized runs
    for (int run = 0; run < 8; run++) begin
      step(1, 0, 2'b00, 2'b00, $urandom_range(0, 1));
      budget = 0;
      while (m_run && budget < 200) begin
        g = 2'($urandom_range(0, 3));
        e = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : g;
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 7) == 0);
        r = ($urandom_range(0, 3) == 0);
        step(s, v, g, e, r);
        budget++;
      end
      check("run_budget", int'(m_run), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 2'b00, 2'b00, $urandom_range(0, 1));
    end

    @(negedge clk);
    #1;
    check("status_queue_drained", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
